// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO push arbiter
// and the pop-side scheduler.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE,
    BURST
  } arb_state_t;

  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_MAX_BURST = 4;

  function automatic int unsigned rr_next(
    input int unsigned ptr,
    input int unsigned n
  );
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester at or
// after ptr_i, wrapping modulo N.
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned N     = DEF_NUM_REQ,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] sel_o,
  output logic             any_o
);

  function automatic logic [IDX_W-1:0] wrap(
    input logic [IDX_W-1:0] p,
    input int unsigned      off
  );
    int unsigned s;
    s = 32'(p) + off;
    if (s >= N) s = s - N;
    return IDX_W'(s);
  endfunction

  // Scan farthest offset first so the nearest requester wins.
  always_comb begin
    sel_o = ptr_i;
    for (int unsigned i = N; i > 0; i--) begin
      if (req_i[wrap(ptr_i, i - 1)]) begin
        sel_o = wrap(ptr_i, i - 1);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin, burst-locking arbiter sharing the parity
// FIFO push port between NUM_REQ producers.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter  int unsigned MAX_BURST  = DEF_MAX_BURST,
  localparam int unsigned IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH:0] req_data_i,
  output logic [NUM_REQ-1:0]               req_grant_o,
  output logic                             fifo_valid_o,
  output logic [DATA_WIDTH:0]              fifo_data_o,
  input  logic                             fifo_grant_i,
  output logic [IDX_W-1:0]                 owner_o,
  output logic                             busy_o
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state_q;
  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] owner_q;
  logic [CNT_W-1:0] cnt_q;

  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] cur;
  logic [IDX_W-1:0] pick_nxt;
  logic [IDX_W-1:0] owner_nxt;
  logic             any;
  logic             busy;
  logic             xfer;
  logic             last_beat;

  rr_priority_picker #(
    .N(NUM_REQ)
  ) u_pick (
    .req_i(req_valid_i),
    .ptr_i(rr_q),
    .sel_o(pick),
    .any_o(any)
  );

  assign busy      = (state_q == BURST);
  assign cur       = busy ? owner_q : pick;
  assign pick_nxt  = IDX_W'(rr_next(32'(pick), NUM_REQ));
  assign owner_nxt = IDX_W'(rr_next(32'(owner_q), NUM_REQ));
  assign last_beat = (cnt_q == CNT_W'(MAX_BURST - 1));

  // Gate with rst_n so nothing is offered while reset is held.
  assign fifo_valid_o = rst_n
                      & (busy ? req_valid_i[owner_q] : any);
  assign fifo_data_o  = req_data_i[cur];
  assign xfer         = fifo_valid_o & fifo_grant_i;
  assign req_grant_o  = xfer ? (NUM_REQ'(1) << cur) : '0;

  assign owner_o = owner_q;
  assign busy_o  = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            if (MAX_BURST == 1) begin
              rr_q <= pick_nxt;
            end else begin
              owner_q <= pick;
              cnt_q   <= CNT_W'(1);
              state_q <= BURST;
            end
          end
        end
        BURST: begin
          if (xfer) begin
            if (last_beat) begin
              rr_q    <= owner_nxt;
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else if (!req_valid_i[owner_q]) begin
            rr_q    <= owner_nxt;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Scoreboard bench for fifo_push_arbiter: burst-4 and
// per-beat (burst-1) instances.
module tb_fifo_push_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;

  typedef struct {
    logic [DW:0]   w;
    logic [NR-1:0] g;
    logic          b;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NR-1:0]       v0, v1, en;
  logic [NR-1:0][DW:0] rdata;
  logic                fgrant;
  logic [NR-1:0]       g0, g1;
  logic                fv0, fv1;
  logic [DW:0]         fd0, fd1;
  logic [1:0]          ow0, ow1;
  logic                b0, b1;

  fifo_push_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(v0), .req_data_i(rdata),
    .req_grant_o(g0), .fifo_valid_o(fv0),
    .fifo_data_o(fd0), .fifo_grant_i(fgrant),
    .owner_o(ow0), .busy_o(b0)
  );

  fifo_push_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(v1), .req_data_i(rdata),
    .req_grant_o(g1), .fifo_valid_o(fv1),
    .fifo_data_o(fd1), .fifo_grant_i(fgrant),
    .owner_o(ow1), .busy_o(b1)
  );

  int   n[NR];
  bit   mode;
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc;

  logic          s_valid;
  logic [NR-1:0] s_grant;
  logic          s_busy;
  logic [1:0]    s_owner;
  logic [DW:0]   s_data;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW:0] word(int k, int m);
    logic [DW-1:0] p;
    p = DW'(k * 256 + m);
    return {^p, p};
  endfunction

  task automatic push(int k, int m, logic b);
    exp_t e;
    e.w = word(k, m);
    e.g = NR'(1) << k;
    e.b = b;
    sb.push_back(e);
  endtask

  task automatic drive();
    for (int k = 0; k < NR; k++) rdata[k] = word(k, n[k]);
    v0 = mode ? '0 : en;
    v1 = mode ? en : '0;
  endtask

  task automatic step();
    exp_t e;
    #1;
    s_valid = mode ? fv1 : fv0;
    s_grant = mode ? g1 : g0;
    s_busy  = mode ? b1 : b0;
    s_owner = mode ? ow1 : ow0;
    s_data  = mode ? fd1 : fd0;
    if (s_valid && fgrant) begin
      if (sb.size() == 0) begin
        chk("unexpected_xfer", 64'(s_data), 64'hdead);
      end else begin
        e = sb.pop_front();
        chk("data", 64'(s_data), 64'(e.w));
        chk("grant", 64'(s_grant), 64'(e.g));
        chk("busy", 64'(s_busy), 64'(e.b));
      end
    end
    @(posedge clk);
    for (int k = 0; k < NR; k++) if (s_grant[k]) n[k]++;
    @(negedge clk);
    drive();
  endtask

  task automatic run(input int maxc, output int c);
    c = 0;
    while (sb.size() > 0 && c < maxc) begin
      step();
      c++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    mode   = 1'b0;
    en     = '1;
    fgrant = 1'b1;
    for (int k = 0; k < NR; k++) n[k] = 0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid", 64'(fv0), 64'd0);
    chk("rst_grant", 64'(g0), 64'd0);
    chk("rst_busy", 64'(b0), 64'd0);
    chk("rst_owner", 64'(ow0), 64'd0);
    chk("rst_valid1", 64'(fv1), 64'd0);
    rst_n = 1'b1;

    // all four valid: 4 beats each in order 0..3
    for (int k = 0; k < NR; k++)
      for (int i = 0; i < 4; i++) push(k, i, i != 0);
    run(40, cyc);
    chk("fair_cycles", 64'(cyc), 64'd16);

    // producers 1 and 2 alternate bursts
    en = 4'b0110;
    drive();
    for (int r = 0; r < 2; r++)
      for (int k = 1; k <= 2; k++)
        for (int i = 0; i < 4; i++)
          push(k, 4 + r * 4 + i, i != 0);
    run(40, cyc);
    chk("pair_cycles", 64'(cyc), 64'd16);

    // backpressure after beat 1
    en = 4'b1000;
    drive();
    for (int i = 0; i < 4; i++) push(3, 4 + i, i != 0);
    step();
    fgrant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_grant", 64'(s_grant), 64'd0);
      chk("bp_owner", 64'(s_owner), 64'd3);
      chk("bp_busy", 64'(s_busy), 64'd1);
    end
    fgrant = 1'b1;
    run(10, cyc);
    chk("bp_cycles", 64'(cyc), 64'd3);
    en = '0;
    drive();
    step();
    chk("bp_idle_busy", 64'(s_busy), 64'd0);
    chk("bp_idle_valid", 64'(s_valid), 64'd0);

    // owner drops valid after 2 beats
    en = 4'b1011;
    drive();
    push(0, 4, 1'b0);
    push(0, 5, 1'b1);
    step();
    step();
    en[0] = 1'b0;
    drive();
    step();
    chk("bubble_valid", 64'(s_valid), 64'd0);
    chk("bubble_grant", 64'(s_grant), 64'd0);
    for (int i = 0; i < 4; i++) push(1, 12 + i, i != 0);
    run(10, cyc);
    chk("drop_cycles", 64'(cyc), 64'd4);
    en = '0;
    drive();

    // reset in the middle of a burst from producer 2
    en = '1;
    drive();
    push(2, 12, 1'b0);
    push(2, 13, 1'b1);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(fv0), 64'd0);
    chk("mid_rst_grant", 64'(g0), 64'd0);
    chk("mid_rst_busy", 64'(b0), 64'd0);
    chk("mid_rst_owner", 64'(ow0), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push(0, 6 + i, i != 0);
    run(10, cyc);
    chk("post_rst_cycles", 64'(cyc), 64'd4);
    en = '0;
    drive();

    // per-beat round robin on the burst-1 instance
    mode = 1'b1;
    for (int k = 0; k < NR; k++) n[k] = 0;
    en = '1;
    drive();
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < NR; k++) push(k, i, 1'b0);
    run(30, cyc);
    chk("rr1_cycles", 64'(cyc), 64'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin arbiter that shares the single push port of the parity FIFO (`top`) between `NUM_REQ` producers. Each producer uses the same valid/grant handshake as the FIFO push port. The arbiter muxes the selected producer's word onto the FIFO push port. Burst locking lets one owner push up to `MAX_BURST` consecutive beats before priority rotates. Data, including the parity bit, passes through unmodified; parity checking stays inside the FIFO.

## Interface
- `DATA_WIDTH`, 32: payload width; every data bus is `DATA_WIDTH+1` bits (payload plus parity).
- `NUM_REQ`, 4: number of producers, 2..16.
- `MAX_BURST`, 4: maximum consecutive beats per ownership, 1..255; 1 gives pure per-beat round-robin.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  NUM_REQ  producer k has a word to push.
- `req_data_i`  in  NUM_REQ x (DATA_WIDTH+1)  producer words, packed.
- `req_grant_o`  out  NUM_REQ  one-hot or zero; bit k high means producer k's word is taken at this edge.
- `fifo_valid_o`  out  1  drives FIFO `push_valid_i`.
- `fifo_data_o`  out  DATA_WIDTH+1  drives FIFO `push_data_i`.
- `fifo_grant_i`  in  1  from FIFO `push_grant_o` (not full).
- `owner_o`  out  $clog2(NUM_REQ)  currently selected producer, for debug.
- `busy_o`  out  1  high while in BURST.

## Operation
- A transfer happens on a rising edge where `fifo_valid_o && fifo_grant_i`. The granted producer and the FIFO both consume the word at that edge.
- Producers hold valid and data stable until granted. The arbiter never drops or duplicates a word.
- State machine with 2 states:
  - IDLE:
    - sel = first k with `req_valid_i[k]`, scanning `rr_ptr`, `rr_ptr+1`, … modulo NUM_REQ.
    - `fifo_valid_o` = |req_valid_i; data = `req_data_i[sel]`; `req_grant_o[sel]` = fifo_grant_i.
    - On transfer: if MAX_BURST==1, `rr_ptr <= sel+1` (mod NUM_REQ) and stay in IDLE; else owner <= sel, beat_cnt <= 1, go to BURST.
  - BURST:
    - Only the owner is considered: `fifo_valid_o` = req_valid_i[owner]; data = req_data_i[owner]; `req_grant_o[owner]` = fifo_grant_i.
    - On transfer, beat_cnt++. If beat_cnt reaches MAX_BURST on that transfer: `rr_ptr <= owner+1`, go to IDLE.
    - Owner valid low: no transfer; `rr_ptr <= owner+1`, go to IDLE. This costs exactly one bubble cycle, which is accepted.
    - `fifo_grant_i` low with owner valid: hold everything; beat_cnt is not incremented.
- `rr_ptr` wraps NUM_REQ-1 → 0. beat_cnt is `$clog2(MAX_BURST+1)` bits wide and never exceeds MAX_BURST.
- Fairness: with all producers valid and the FIFO always granting, each producer receives exactly MAX_BURST beats per rotation, in order 0,1,…,NUM_REQ-1.

## Timing
- Zero latency: data/valid mux and `req_grant_o` are combinational from `req_valid_i`, `fifo_grant_i` and registered state. There is no combinational path from `req_data_i` to any grant.
- Reset (`rst_n` low, asynchronous):
  - state IDLE, rr_ptr 0, owner 0, beat_cnt 0.
  - `fifo_valid_o`, `req_grant_o`, `busy_o` forced 0 for the whole reset, regardless of inputs; `owner_o` reads 0.
- Reset asserted mid-burst abandons the burst. No partial word is pushed; words the FIFO already accepted are the FIFO's concern, since the FIFO shares the same reset.
- First transfer after reset release can occur at the first rising edge with `rst_n` high.

## Structure
- Package `fifo_arb_pkg`: `arb_state_t` enum {IDLE, BURST} and `function automatic rr_next(ptr, n)`. Width constants come from `$clog2` of the parameters.
- Sub-module `rr_priority_picker`: purely combinational; inputs req vector and rr_ptr, outputs sel index and `any` flag. Reused by the pop-side scheduler later.
- The top-level arbiter holds the FSM, rr_ptr, owner, beat_cnt and the output mux. Target about 200 lines total.

## Test plan
- Reset mid-burst: owner 2, beat_cnt 2, pull rst_n low between edges -> grants and `fifo_valid_o` drop immediately; after release rr_ptr=0 and producer 0 wins when all are valid.
- MAX_BURST=1, all 4 valid, fifo_grant_i=1, producer k sends k*16+n -> FIFO receives 0,16,32,48,1,17,… with one grant per cycle.
- MAX_BURST=4, producers 1 and 2 continuously valid -> 4 beats from 1, then 4 from 2, then 1 again; `busy_o` high during beats 2-4 of each ownership.
- Backpressure: fifo_grant_i=0 for 3 cycles after beat 1 of a burst -> no grants, owner and beat_cnt held; the remaining 3 beats complete once grant returns.
- Owner drops valid after 2 of 4 beats -> one cycle with fifo_valid_o=0, then the next valid producer after the owner is granted.
- End-to-end with `top` (FIFO_DEPTH=4, parity even): 3 producers push 6 correctly-parity words each, consumer pops continuously -> 18 words emerge in grant order with no loss or duplication; one corrupted-parity word is discarded by the FIFO, not by the arbiter.
